multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit: IF/ID/EX/MEM/WB sequencer plus a
// combinational op/func decode that drives the datapath level controls.
module multicycle_control_unit #(
   parameter int WAIT_MEM = 1,
   parameter int ALUC_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        op,
   input  logic [5:0]        func,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pcwrite,
   output logic              irwrite,
   output logic [1:0]        pcsource,
   output logic [ALUC_W-1:0] aluc,
   output logic              rmem,
   output logic              wmem,
   output logic              shift,
   output logic              wreg,
   output logic              alumm,
   output logic              mtoreg,
   output logic              sext,
   output logic              jal,
   output logic              regrt,
   output logic [2:0]        state,
   output logic              illegal,
   output logic              retire
);

   localparam logic [ALUC_W-1:0] ALUC_NOP = ALUC_W'(0);
   localparam logic [ALUC_W-1:0] ALUC_ADD = ALUC_W'(1);
   localparam logic [ALUC_W-1:0] ALUC_SUB = ALUC_W'(2);
   localparam logic [ALUC_W-1:0] ALUC_AND = ALUC_W'(3);
   localparam logic [ALUC_W-1:0] ALUC_OR  = ALUC_W'(4);
   localparam logic [ALUC_W-1:0] ALUC_XOR = ALUC_W'(5);
   localparam logic [ALUC_W-1:0] ALUC_SLL = ALUC_W'(6);
   localparam logic [ALUC_W-1:0] ALUC_SRL = ALUC_W'(7);
   localparam logic [ALUC_W-1:0] ALUC_SRA = ALUC_W'(8);
   localparam logic [ALUC_W-1:0] ALUC_LUI = ALUC_W'(9);

   localparam logic [1:0] PCS_SEQ    = 2'b00;
   localparam logic [1:0] PCS_BRANCH = 2'b01;
   localparam logic [1:0] PCS_REG    = 2'b10;
   localparam logic [1:0] PCS_JUMP   = 2'b11;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [4:0] {
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA, I_JR,
      I_ADDI, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW,
      I_BEQ, I_BNE, I_J, I_JAL, I_ILL
   } instr_t;

   state_t cur, nxt;
   instr_t instr;
   logic   mem_done;
   logic   pcwrite_c, irwrite_c, rmem_c, wmem_c, wreg_c, jal_c, illegal_c, retire_c;

   // A memory access finishes on mem_ready, or immediately in no-wait builds.
   assign mem_done = (WAIT_MEM == 0) || mem_ready;
   assign state    = cur;

   // Instruction classification from the instruction register fields.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      instr = I_ILL;
      case (op)
         6'b000000:
            case (func)
               6'b100000: instr = I_ADD;
               6'b100010: instr = I_SUB;
               6'b100100: instr = I_AND;
               6'b100101: instr = I_OR;
               6'b100110: instr = I_XOR;
               6'b000000: instr = I_SLL;
               6'b000010: instr = I_SRL;
               6'b000011: instr = I_SRA;
               6'b001000: instr = I_JR;
               default:   instr = I_ILL;
            endcase
         6'b001000: instr = I_ADDI;
         6'b001100: instr = I_ANDI;
         6'b001101: instr = I_ORI;
         6'b001110: instr = I_XORI;
         6'b001111: instr = I_LUI;
         6'b100011: instr = I_LW;
         6'b101011: instr = I_SW;
         6'b000100: instr = I_BEQ;
         6'b000101: instr = I_BNE;
         6'b000010: instr = I_J;
         6'b000011: instr = I_JAL;
         default:   instr = I_ILL;
      endcase
   end

   // Level controls: same in every state, like a single-cycle decoder.
   always_comb begin
      aluc   = ALUC_NOP;
      shift  = 1'b0;
      alumm  = 1'b0;
      sext   = 1'b0;
      regrt  = 1'b0;
      mtoreg = 1'b0;
      case (instr)
         I_ADD:  aluc = ALUC_ADD;
         I_SUB:  aluc = ALUC_SUB;
         I_AND:  aluc = ALUC_AND;
         I_OR:   aluc = ALUC_OR;
         I_XOR:  aluc = ALUC_XOR;
         I_SLL:  begin aluc = ALUC_SLL; shift = 1'b1; end
         I_SRL:  begin aluc = ALUC_SRL; shift = 1'b1; end
         I_SRA:  begin aluc = ALUC_SRA; shift = 1'b1; end
         I_ADDI: begin aluc = ALUC_ADD; sext = 1'b1; alumm = 1'b1; regrt = 1'b1; end
         I_ANDI: begin aluc = ALUC_AND; alumm = 1'b1; regrt = 1'b1; end
         I_ORI:  begin aluc = ALUC_OR;  alumm = 1'b1; regrt = 1'b1; end
         I_XORI: begin aluc = ALUC_XOR; alumm = 1'b1; regrt = 1'b1; end
         I_LUI:  begin aluc = ALUC_LUI; alumm = 1'b1; regrt = 1'b1; end
         I_LW:   begin aluc = ALUC_ADD; sext = 1'b1; alumm = 1'b1; regrt = 1'b1; mtoreg = 1'b1; end
         I_SW:   begin aluc = ALUC_ADD; sext = 1'b1; alumm = 1'b1; end
         I_BEQ:  begin aluc = ALUC_SUB; sext = 1'b1; end
         I_BNE:  begin aluc = ALUC_XOR; sext = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (!rst_n) cur <= S_IF;
      else        cur <= nxt;
   end

   always_comb begin
      nxt = S_IF;
      case (cur)
         S_IF: nxt = mem_done ? S_ID : S_IF;
         S_ID:
            case (instr)
               I_J, I_JAL, I_JR, I_ILL: nxt = S_IF;
               default:                 nxt = S_EX;
            endcase
         S_EX:
            case (instr)
               I_BEQ, I_BNE: nxt = S_IF;
               I_LW, I_SW:   nxt = S_MEM;
               default:      nxt = S_WB;
            endcase
         S_MEM:
            if (!mem_done)        nxt = S_MEM;
            else if (instr == I_LW) nxt = S_WB;
            else                  nxt = S_IF;
         S_WB:    nxt = S_IF;
         default: nxt = S_IF;
      endcase
   end

   always_comb begin
      pcwrite_c = 1'b0;
      irwrite_c = 1'b0;
      rmem_c    = 1'b0;
      wmem_c    = 1'b0;
      wreg_c    = 1'b0;
      jal_c     = 1'b0;
      illegal_c = 1'b0;
      retire_c  = 1'b0;
      pcsource  = PCS_SEQ;
      case (cur)
         S_IF: begin
            rmem_c = 1'b1;
            if (mem_done) begin
               irwrite_c = 1'b1;
               pcwrite_c = 1'b1;
            end
         end
         S_ID:
            case (instr)
               I_J:   begin pcwrite_c = 1'b1; pcsource = PCS_JUMP; retire_c = 1'b1; end
               I_JAL: begin
                  pcwrite_c = 1'b1; pcsource = PCS_JUMP; retire_c = 1'b1;
                  wreg_c = 1'b1; jal_c = 1'b1;
               end
               I_JR:  begin pcwrite_c = 1'b1; pcsource = PCS_REG; retire_c = 1'b1; end
               I_ILL: begin illegal_c = 1'b1; retire_c = 1'b1; end
               default: ;
            endcase
         S_EX:
            case (instr)
               I_BEQ: begin pcwrite_c = zero;  pcsource = PCS_BRANCH; retire_c = 1'b1; end
               I_BNE: begin pcwrite_c = ~zero; pcsource = PCS_BRANCH; retire_c = 1'b1; end
               default: ;
            endcase
         S_MEM:
            case (instr)
               I_LW: rmem_c = 1'b1;
               I_SW: begin wmem_c = 1'b1; retire_c = mem_done; end
               default: ;
            endcase
         S_WB: begin
            wreg_c   = 1'b1;
            retire_c = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: reset gates strobes combinationally so an aborted access never writes or retires.
   assign pcwrite = rst_n & pcwrite_c;
   assign irwrite = rst_n & irwrite_c;
   assign rmem    = rst_n & rmem_c;
   assign wmem    = rst_n & wmem_c;
   assign wreg    = rst_n & wreg_c;
   assign jal     = rst_n & jal_c;
   assign illegal = rst_n & illegal_c;
   assign retire  = rst_n & retire_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one WAIT_MEM=1 instance and one
// WAIT_MEM=0 instance with mem_ready tied low; ALUC codes: NOP 0, ADD 1, SUB 2,
// AND 3, OR 4, XOR 5, SLL 6, SRL 7, SRA 8, LUI 9.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       rst_n, rst_n2, zero, mem_ready, use2;
   logic [5:0] op, func;

   logic       pcwrite, irwrite, rmem, wmem, shift, wreg, alumm, mtoreg, sext, jal, regrt, illegal, retire;
   logic [1:0] pcsource;
   logic [3:0] aluc;
   logic [2:0] state;

   logic       pcwrite2, irwrite2, rmem2, wmem2, shift2, wreg2, alumm2, mtoreg2, sext2, jal2, regrt2, illegal2, retire2;
   logic [1:0] pcsource2;
   logic [3:0] aluc2;
   logic [2:0] state2;

   logic [7:0] obs_strb;
   logic [2:0] obs_state;
   logic [1:0] obs_pcs;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.WAIT_MEM(1), .ALUC_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .irwrite(irwrite), .pcsource(pcsource), .aluc(aluc), .rmem(rmem),
      .wmem(wmem), .shift(shift), .wreg(wreg), .alumm(alumm), .mtoreg(mtoreg), .sext(sext),
      .jal(jal), .regrt(regrt), .state(state), .illegal(illegal), .retire(retire)
   );

   multicycle_control_unit #(.WAIT_MEM(0), .ALUC_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n2), .op(op), .func(func), .zero(zero), .mem_ready(1'b0),
      .pcwrite(pcwrite2), .irwrite(irwrite2), .pcsource(pcsource2), .aluc(aluc2), .rmem(rmem2),
      .wmem(wmem2), .shift(shift2), .wreg(wreg2), .alumm(alumm2), .mtoreg(mtoreg2), .sext(sext2),
      .jal(jal2), .regrt(regrt2), .state(state2), .illegal(illegal2), .retire(retire2)
   );

   // Strobe vector order: {pcwrite, irwrite, rmem, wmem, wreg, jal, illegal, retire}
   assign obs_strb  = use2 ? {pcwrite2, irwrite2, rmem2, wmem2, wreg2, jal2, illegal2, retire2}
                           : {pcwrite, irwrite, rmem, wmem, wreg, jal, illegal, retire};
   assign obs_state = use2 ? state2 : state;
   assign obs_pcs   = use2 ? pcsource2 : pcsource;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check state, strobes and pcsource, then move to the next negedge.
   task automatic step(input string tag, input logic [2:0] est, input logic [7:0] estb,
                       input logic [1:0] epc);
      #1;
      check({tag, ".state"}, 32'(obs_state), 32'(est));
      check({tag, ".strobes"}, 32'(obs_strb), 32'(estb));
      check({tag, ".pcsource"}, 32'(obs_pcs), 32'(epc));
      @(negedge clk);
   endtask

   // Level vector order: {shift, alumm, sext, regrt, mtoreg}
   task automatic lvl(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic [3:0] ea, input logic [4:0] el);
      op = o; func = f;
      #1;
      check({tag, ".aluc"}, 32'(aluc), 32'(ea));
      check({tag, ".levels"}, 32'({shift, alumm, sext, regrt, mtoreg}), 32'(el));
   endtask

   task automatic branch(input string tag, input logic [5:0] o, input logic z,
                         input logic [7:0] ex_strb);
      op = o; zero = z; mem_ready = 1'b1;
      step({tag, ".if"}, 3'd0, 8'hE0, 2'b00);
      step({tag, ".id"}, 3'd1, 8'h00, 2'b00);
      step({tag, ".ex"}, 3'd2, ex_strb, 2'b01);
   endtask

   initial begin
      use2 = 1'b0; rst_n = 1'b0; rst_n2 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      op = 6'b000000; func = 6'b100000;
      @(negedge clk);

      // Reset: state IF and all strobes forced low even though mem_ready is high.
      step("reset", 3'd0, 8'h00, 2'b00);

      // ADD: IF, ID, EX, WB with retire in the fourth cycle.
      rst_n = 1'b1;
      step("add.if", 3'd0, 8'hE0, 2'b00);
      step("add.id", 3'd1, 8'h00, 2'b00);
      check("add.aluc", 32'(aluc), 32'd1);
      step("add.ex", 3'd2, 8'h00, 2'b00);
      step("add.wb", 3'd4, 8'h09, 2'b00);

      // Level decode sweep while IF stalls on mem_ready low.
      mem_ready = 1'b0;
      lvl("sub",  6'b000000, 6'b100010, 4'd2, 5'b00000);
      lvl("sra",  6'b000000, 6'b000011, 4'd8, 5'b10000);
      lvl("addi", 6'b001000, 6'b000000, 4'd1, 5'b01110);
      lvl("ori",  6'b001101, 6'b000000, 4'd4, 5'b01010);
      lvl("lui",  6'b001111, 6'b000000, 4'd9, 5'b01010);
      lvl("lw",   6'b100011, 6'b000000, 4'd1, 5'b01111);
      lvl("sw",   6'b101011, 6'b000000, 4'd1, 5'b01100);
      lvl("beq",  6'b000100, 6'b000000, 4'd2, 5'b00100);
      lvl("bne",  6'b000101, 6'b000000, 4'd5, 5'b00100);
      lvl("ill",  6'b111111, 6'b000000, 4'd0, 5'b00000);
      lvl("badf", 6'b000000, 6'b111111, 4'd0, 5'b00000);
      @(negedge clk);
      step("if.wait", 3'd0, 8'h20, 2'b00);

      // LW with two MEM wait cycles: seven cycles total.
      op = 6'b100011; mem_ready = 1'b1;
      step("lw.if", 3'd0, 8'hE0, 2'b00);
      step("lw.id", 3'd1, 8'h00, 2'b00);
      mem_ready = 1'b0;
      step("lw.ex", 3'd2, 8'h00, 2'b00);
      step("lw.mem1", 3'd3, 8'h20, 2'b00);
      step("lw.mem2", 3'd3, 8'h20, 2'b00);
      mem_ready = 1'b1;
      step("lw.mem3", 3'd3, 8'h20, 2'b00);
      check("lw.mtoreg", 32'(mtoreg), 32'd1);
      step("lw.wb", 3'd4, 8'h09, 2'b00);

      // Branches: taken gives pcwrite+retire (0x81), not taken retire only (0x01).
      branch("beq.z1", 6'b000100, 1'b1, 8'h81);
      branch("beq.z0", 6'b000100, 1'b0, 8'h01);
      branch("bne.z1", 6'b000101, 1'b1, 8'h01);
      branch("bne.z0", 6'b000101, 1'b0, 8'h81);

      // JAL and JR finish in ID.
      op = 6'b000011;
      step("jal.if", 3'd0, 8'hE0, 2'b00);
      step("jal.id", 3'd1, 8'h8D, 2'b11);
      op = 6'b000000; func = 6'b001000;
      step("jr.if", 3'd0, 8'hE0, 2'b00);
      step("jr.id", 3'd1, 8'h81, 2'b10);

      // Undecoded op: illegal and retire together in ID, then back to IF.
      op = 6'b111111;
      step("ill.if", 3'd0, 8'hE0, 2'b00);
      step("ill.id", 3'd1, 8'h03, 2'b00);

      // SW aborted by reset while waiting in MEM.
      op = 6'b101011;
      step("sw.if", 3'd0, 8'hE0, 2'b00);
      step("sw.id", 3'd1, 8'h00, 2'b00);
      mem_ready = 1'b0;
      step("sw.ex", 3'd2, 8'h00, 2'b00);
      step("sw.mem", 3'd3, 8'h10, 2'b00);
      rst_n = 1'b0;
      step("sw.rst", 3'd3, 8'h00, 2'b00);
      rst_n = 1'b1; mem_ready = 1'b1;
      step("sw.after", 3'd0, 8'hE0, 2'b00);

      // No-wait build: SW completes in four cycles with mem_ready tied low.
      use2 = 1'b1; rst_n2 = 1'b1;
      step("nw.sw.if", 3'd0, 8'hE0, 2'b00);
      step("nw.sw.id", 3'd1, 8'h00, 2'b00);
      check("nw.sw.aluc", 32'(aluc2), 32'd1);
      check("nw.sw.levels", 32'({shift2, alumm2, sext2, regrt2, mtoreg2}), 32'(5'b01100));
      step("nw.sw.ex", 3'd2, 8'h00, 2'b00);
      step("nw.sw.mem", 3'd3, 8'h11, 2'b00);
      step("nw.next", 3'd0, 8'hE0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
